exec_hazard_ctrl: RTL

//  Pipeline sequencer for the execute datapath. Tracks the shadow EX/MEM/WB occupancy
//  (valid, dest reg, halt) and stalls decode on RAW hazards. Flushes the wrong-path

---
 rtl/exec_hazard_ctrl.sv | 72 +++++++
 1 files changed

// File: rtl/exec_hazard_ctrl.sv
// exec_hazard_ctrl: EX/MEM/WB occupancy tracking, RAW stall, branch flush and halt/error freeze
module exec_hazard_ctrl #(
  parameter int RA_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [RA_W-1:0]  id_wr_reg,
  input  logic             id_halt,
  input  logic             ex_take_br,
  input  logic             ex_err,
  output logic             stall,
  output logic             flush_id,
  output logic             issue,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic             halt,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;
  logic [1:0] state;
  logic ex_v, ex_we, ex_h, mem_v, mem_we, mem_h, wb_v, wb_h;
  logic [RA_W-1:0] ex_rd, mem_rd;
  logic run, br, hazard, hz_ex, hz_mem;
  always_comb begin
    run      = state == RUN;
    br       = ex_take_br & ex_v;
    hz_ex    = ex_v & ex_we & ((id_use_rs & id_rs == ex_rd) | (id_use_rt & id_rt == ex_rd));
    hz_mem   = mem_v & mem_we & ((id_use_rs & id_rs == mem_rd) | (id_use_rt & id_rt == mem_rd));
    hazard   = id_valid & (hz_ex | hz_mem);
    stall    = !run | (!br & hazard);
    flush_id = run & br;
    issue    = run & !br & !hazard & id_valid;
    halt     = state == HALTED;
    ex_valid  = ex_v & !halt;
    mem_valid = mem_v & !halt;
    wb_valid  = wb_v & !halt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      err <= 1'b0;
      stall_cnt <= '0;
      {ex_v, ex_we, ex_h, ex_rd} <= '0;
      {mem_v, mem_we, mem_h, mem_rd} <= '0;
      {wb_v, wb_h} <= '0;
    end else begin
      if (stall & run & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
      if (!halt) begin
        {wb_v, wb_h} <= {mem_v, mem_h};
        {mem_v, mem_we, mem_h, mem_rd} <= {ex_v, ex_we, ex_h, ex_rd};
        {ex_v, ex_we, ex_h, ex_rd} <= issue ? {1'b1, id_wr_en, id_halt, id_wr_reg} : '0;
      end
      // An execute error wins over normal sequencing in any live state
      if (ex_err & ex_valid) begin
        state <= HALTED;
        err <= 1'b1;
      end else if (run & issue & id_halt) state <= DRAIN;
      else if (state == DRAIN & wb_v & wb_h) state <= HALTED;
    end
  end
endmodule
